spi_master: RTL
===============

# spi_master

Synchronous SPI master (mode 0: CPOL=0, CPHA=0, MSB first). It drives chip-select, serial clock and MOSI, and captures MISO into a parallel word. It is the initiator-side counterpart of the peripheral shift-register datapath: it generates the serial clock that the peripheral edge-detects, and shifts bits in at the LSB exactly as the peripheral does. It sits between a host-side command interface (start/data/done) and the off-block SPI pins.

## Interface
- WIDTH, 8, bits per transfer; must be ≥ 2
- CLKDIV, 4, `clk` cycles per SCLK half-period; must be ≥ 1
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; accepted only when `busy`=0
- txData  input  WIDTH  word to transmit; captured on the accepting cycle
- rxData  output  WIDTH  last received word; updated when `done` pulses
- busy  output  1  high from the cycle after acceptance through the `done` cycle
- done  output  1  one-cycle pulse at end of transfer
- csN  output  1  chip select, active low
- sclk  output  1  serial clock, idles low
- mosi  output  1  serial data out
- miso  input  1  serial data in

## Operation
- Reset values: csN=1, sclk=0, mosi=0, busy=0, done=0, rxData=0, state IDLE, counters 0.
- States: IDLE → SETUP → SHIFT_HI ↔ SHIFT_LO → HOLD → DONE → IDLE.
- IDLE: on `start`=1, load `txData` into the TX shift register, clear the bit counter, and go to SETUP. In the same edge: csN←0, mosi←txData[WIDTH-1], busy←1.
- SETUP: wait CLKDIV cycles, then sclk←1, sample miso into RX bit 0 (RX shifts left, new bit enters at the LSB), and go to SHIFT_HI.
- SHIFT_HI: after CLKDIV cycles, sclk←0 and increment the bit counter.
  - If the count has reached WIDTH, go to HOLD.
  - Otherwise shift TX left, set mosi to the new MSB, and go to SHIFT_LO.
- SHIFT_LO: after CLKDIV cycles, sclk←1, sample miso, and go to SHIFT_HI.
- HOLD: after CLKDIV cycles, csN←1, mosi←0, rxData←RX register, done←1, and go to DONE.
- DONE: one cycle; done←0, busy←0, go to IDLE.
- A `start` asserted while busy=1 (including the DONE cycle) is ignored, not queued.
- `txData` changes after acceptance have no effect.
- Exactly WIDTH rising SCLK edges per transfer. MOSI changes only on the falling edge or at csN assertion, never on a rising edge.
- Async reset mid-transfer: all outputs return to their reset values immediately. No `done` is produced and rxData is cleared.

## Timing
- Acceptance edge = cycle 0. csN low from cycle 1.
- Rising SCLK edge k (k = 0..WIDTH-1) occurs at cycle 1 + CLKDIV + 2·k·CLKDIV.
- MISO is sampled at the same clk edge that raises SCLK.
- csN rises and `done` pulses at cycle 1 + (2·WIDTH+1)·CLKDIV. busy falls one cycle later.
- Back-to-back: the earliest next acceptance is the cycle after DONE, so csN stays high for at least 2 cycles between transfers.
- Half-period counter width is $clog2(CLKDIV+1). Bit counter width is $clog2(WIDTH+1). Both counters wrap only through explicit clear.

## Configuration
- SPI_MASTER_LOOPBACK_EN defined: the internal sampled serial input is `mosi`, and the `miso` port is ignored. A transfer then returns rxData == txData. This mode is for bring-up and self-test.
- Not defined: sampling uses the `miso` port; no loopback logic is present.

## Structure
- Shared package `spi_pkg`:
  - state enum `spi_state_t` (IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, DONE)
  - constants SPI_CPOL=0, SPI_CPHA=0, SPI_MSB_FIRST=1
  - these are shared with the peripheral-side blocks
- One sub-module: `spi_clk_div`. It is the half-period counter and emits a one-cycle `tick` every CLKDIV cycles while enabled. It clears on disable and on reset.
- The FSM, shift registers and bit counter live in `spi_master`.

## Test plan
- Reset: hold rst_n=0 while start=1 → csN=1, sclk=0, mosi=0, busy=0, rxData=0 throughout.
- WIDTH=8, CLKDIV=2, txData=8'hA5, miso model returns 8'h3C MSB-first on falling edges → mosi sequence 1,0,1,0,0,1,0,1 at the rising edges; exactly 8 rising edges; done at cycle 35; rxData=8'h3C.
- `start` pulsed at cycles 5 and 20 during a transfer → ignored; only one csN low window and one `done`.
- Back-to-back: start again on the cycle after busy falls, with 8'hFF then 8'h00 → two clean frames; csN high ≥ 2 cycles between them; rxData updates each frame.
- Reset asserted at SCLK edge 4 of a transfer → outputs go to reset values asynchronously; no `done`; the next transfer completes correctly.
- SPI_MASTER_LOOPBACK_EN defined, txData=8'h5A, miso tied 0 → rxData=8'h5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and mode constants used by both
// the master and the peripheral-side blocks.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    DONE
  } spi_state_t;

  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_CPHA      = 1'b0;
  localparam logic SPI_MSB_FIRST = 1'b1;

  // The half-period divider runs only while a frame is on the wire.
  function automatic logic div_active(spi_state_t s);
    return (s == SETUP) || (s == SHIFT_HI) || (s == SHIFT_LO) || (s == HOLD);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host command signals and SPI pins of spi_master, grouped for port binding.
interface spi_master_if #(
  parameter int WIDTH = 8
);
  // Handshake: start is a single-cycle request taken only while busy=0; the
  // word on txData is captured on that cycle. busy rises the next cycle and
  // stays high through the single-cycle done pulse that also updates rxData.
  logic             start;
  logic [WIDTH-1:0] txData;
  logic [WIDTH-1:0] rxData;
  logic             busy;
  logic             done;
  logic             csN;
  logic             sclk;
  logic             mosi;
  logic             miso;

  modport master (
    input  start, txData, miso,
    output rxData, busy, done, csN, sclk, mosi
  );

  modport slave (
    output start, txData, miso,
    input  rxData, busy, done, csN, sclk, mosi
  );
endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period counter: pulses tick every CLKDIV cycles while enabled.
module spi_clk_div #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLKDIV + 1);

  logic [CW-1:0] cnt;

  // Counting from 0 after enable gives the first phase one extra cycle, which
  // is the csN-to-first-SCLK setup slot; later phases reload to 1.
  assign tick = en && (cnt == CW'(CLKDIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= CW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first. Define SPI_MASTER_LOOPBACK_EN to sample mosi
// instead of the miso pin (bring-up / self-test).
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_if.master      bus,
  output spi_state_t        dbg_state
);

  localparam int BW = $clog2(WIDTH + 1);

  spi_state_t       state, state_n;
  logic [WIDTH-1:0] tx_sr, tx_n;
  logic [WIDTH-1:0] rx_sr, rx_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic             csn_n, sclk_n, mosi_n, busy_n, done_n;
  logic [WIDTH-1:0] rxd_n;
  logic             tick;
  logic             sin;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign sin = bus.mosi;
`else
  assign sin = bus.miso;
`endif

  assign dbg_state = state;

  spi_clk_div #(.CLKDIV(CLKDIV)) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_active(state)),
    .tick  (tick)
  );

  always_comb begin
    state_n = state;
    tx_n    = tx_sr;
    rx_n    = rx_sr;
    bit_n   = bit_cnt;
    csn_n   = bus.csN;
    sclk_n  = bus.sclk;
    mosi_n  = bus.mosi;
    busy_n  = bus.busy;
    done_n  = bus.done;
    rxd_n   = bus.rxData;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = SETUP;
          tx_n    = bus.txData;
          bit_n   = '0;
          csn_n   = 1'b0;
          mosi_n  = bus.txData[WIDTH-1];
          busy_n  = 1'b1;
        end
      end
      SETUP, SHIFT_LO: begin
        if (tick) begin
          sclk_n  = 1'b1;
          rx_n    = {rx_sr[WIDTH-2:0], sin};
          state_n = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (tick) begin
          sclk_n = 1'b0;
          bit_n  = bit_cnt + BW'(1);
          if (bit_cnt == BW'(WIDTH - 1)) begin
            state_n = HOLD;
          end else begin
            // mosi moves only here, on the falling SCLK edge
            tx_n    = {tx_sr[WIDTH-2:0], 1'b0};
            mosi_n  = tx_sr[WIDTH-2];
            state_n = SHIFT_LO;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          csn_n   = 1'b1;
          mosi_n  = 1'b0;
          rxd_n   = rx_sr;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        done_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      bus.csN    <= 1'b1;
      bus.sclk   <= 1'b0;
      bus.mosi   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.rxData <= '0;
    end else begin
      state      <= state_n;
      tx_sr      <= tx_n;
      rx_sr      <= rx_n;
      bit_cnt    <= bit_n;
      bus.csN    <= csn_n;
      bus.sclk   <= sclk_n;
      bus.mosi   <= mosi_n;
      bus.busy   <= busy_n;
      bus.done   <= done_n;
      bus.rxData <= rxd_n;
    end
  end

endmodule
